impact_resonator: RTL and testbench

Audio responder for the orchestrator's impact strobes: latches each `trigger_resonator` strike with its `tension`, plays an attack/decay enveloped triangle tone, and advances it once per `update_resonator` sample strobe. Produces an 8-bit unsigned sample plus an optional 1-bit PWM pin for the board's audio output. Sits between the orchestrator and the top-level audio pin.

---
 rtl/resonator_pkg.sv | 35 +++
 rtl/impact_resonator_if.sv | 20 ++
 rtl/resonator_envelope.sv | 67 ++++++
 rtl/impact_resonator.sv | 107 ++++++++++
 tb/tb_impact_resonator.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/resonator_pkg.sv
// Shared definitions for the impact resonator: envelope states, strike
// strength levels and default tone/envelope constants.
package resonator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ATTACK = 2'd1,
    DECAY  = 2'd2
  } res_state_t;

  localparam logic [7:0]  LVL_WEAK   = 8'h55;
  localparam logic [7:0]  LVL_MEDIUM = 8'hAA;
  localparam logic [7:0]  LVL_STRONG = 8'hFF;

  localparam logic [15:0] BASE_INC     = 16'd512;
  localparam logic [15:0] TENSION_STEP = 16'd256;
  localparam logic [7:0]  ATTACK_STEP  = 8'd32;
  localparam int          DECAY_SHIFT  = 4;

  // Map a strike strength to its envelope target level (0 means no strike).
  function automatic logic [7:0] strength_level(input logic [1:0] strength);
    case (strength)
      2'd1:    strength_level = LVL_WEAK;
      2'd2:    strength_level = LVL_MEDIUM;
      2'd3:    strength_level = LVL_STRONG;
      default: strength_level = 8'h00;
    endcase
  endfunction

  // Phase increment for a tension value; max 512 + 15*256 = 4352 fits 16 bits.
  function automatic logic [15:0] strike_inc(input logic [3:0] tension);
    strike_inc = BASE_INC + 16'(tension) * TENSION_STEP;
  endfunction

endpackage

// File: rtl/impact_resonator_if.sv
// Orchestrator <-> resonator signal bundle. The master side issues strikes
// and sample strobes; the slave side (the resonator) returns audio.
interface impact_resonator_if;
  logic       update_resonator;
  logic [1:0] trigger_resonator;
  logic [3:0] tension;
  logic [7:0] sample_out;
  logic       pwm_out;
  logic       busy;

  modport master (
    output update_resonator, trigger_resonator, tension,
    input  sample_out, pwm_out, busy
  );

  modport slave (
    input  update_resonator, trigger_resonator, tension,
    output sample_out, pwm_out, busy
  );
endinterface

// File: rtl/resonator_envelope.sv
// Attack/decay envelope generator. Advances only on sample strobes; an
// effective strike on a strobe restarts the attack from the first step.
module resonator_envelope
  import resonator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe_i,
  input  logic       strike_i,
  input  logic [7:0] target_i,
  output logic [7:0] env_o,
  output logic       busy_o
);

  res_state_t state_q;
  logic [7:0] env_q;
  logic [7:0] target_q;

  logic [8:0] attack_sum;
  logic [7:0] attack_env;
  logic [7:0] decay_step;
  logic [7:0] decay_env;
  logic [7:0] first_env;

  // Candidate next envelope values for each state.
  always_comb begin
    attack_sum = {1'b0, env_q} + {1'b0, ATTACK_STEP};
    attack_env = (attack_sum > {1'b0, target_q}) ? target_q : attack_sum[7:0];
    decay_step = (env_q >> DECAY_SHIFT) | 8'd1;
    decay_env  = (env_q > decay_step) ? (env_q - decay_step) : 8'd0;
    first_env  = (ATTACK_STEP > target_i) ? target_i : ATTACK_STEP;
  end

  // Envelope state machine, evaluated once per strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      env_q    <= 8'd0;
      target_q <= 8'd0;
    end else if (strobe_i) begin
      if (strike_i) begin
        state_q  <= ATTACK;
        target_q <= target_i;
        env_q    <= first_env;
      end else begin
        case (state_q)
          ATTACK: begin
            env_q <= attack_env;
            if (attack_env == target_q) state_q <= DECAY;
          end
          DECAY: begin
            env_q <= decay_env;
            if (decay_env == 8'd0) state_q <= IDLE;
          end
          default: begin
            env_q   <= 8'd0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign env_o  = env_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/impact_resonator.sv
// Impact resonator top: captures strikes, runs the phase accumulator,
// shapes a triangle by the envelope and drives the sample and PWM pin.
// Optional feature macro: RESONATOR_PWM_EN (builds the PWM output).
module impact_resonator
  import resonator_pkg::*;
(
  input logic          clk,
  input logic          rst,
  impact_resonator_if.slave bus
);

  logic        pend_q;
  logic [7:0]  pend_lvl_q;
  logic [15:0] pend_inc_q;
  logic [15:0] inc_q;
  logic [15:0] phase_q;
  logic [7:0]  sample_q;

  logic        strobe;
  logic        strike;
  logic        strike_eff;
  logic [7:0]  eff_lvl;
  logic [15:0] eff_inc;
  logic [7:0]  tri_val;
  logic [15:0] product;
  logic [7:0]  env;
  logic        busy;

  // A strike arriving with the strobe beats any older pending strike.
  always_comb begin
    strobe     = bus.update_resonator;
    strike     = (bus.trigger_resonator != 2'd0);
    strike_eff = strobe & (strike | pend_q);
    eff_lvl    = strike ? strength_level(bus.trigger_resonator) : pend_lvl_q;
    eff_inc    = strike ? strike_inc(bus.tension) : pend_inc_q;
    tri_val    = phase_q[15] ? ~phase_q[14:7] : phase_q[14:7];
    product    = 16'(tri_val) * 16'(env);
  end

  // Strike latch: last strike between strobes wins, cleared on every strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_lvl_q <= 8'd0;
      pend_inc_q <= 16'd0;
    end else if (strobe) begin
      pend_q <= 1'b0;
    end else if (strike) begin
      pend_q     <= 1'b1;
      pend_lvl_q <= strength_level(bus.trigger_resonator);
      pend_inc_q <= strike_inc(bus.tension);
    end
  end

  // Phase accumulator and sample register; the sample uses pre-update state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q    <= 16'd0;
      phase_q  <= 16'd0;
      sample_q <= 8'd0;
    end else if (strobe) begin
      sample_q <= product[15:8];
      if (strike_eff) begin
        inc_q   <= eff_inc;
        phase_q <= 16'd0;
      end else if (busy) begin
        phase_q <= phase_q + inc_q;
      end else begin
        phase_q <= 16'd0;
      end
    end
  end

  resonator_envelope u_env (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (strobe),
    .strike_i (strike_eff),
    .target_i (eff_lvl),
    .env_o    (env),
    .busy_o   (busy)
  );

`ifdef RESONATOR_PWM_EN
  logic [7:0] pwm_cnt_q;
  logic       pwm_q;

  // Free-running PWM ramp compared against the current sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= 8'd0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_q     <= (pwm_cnt_q < sample_q);
    end
  end

  assign bus.pwm_out = pwm_q;
`else
  assign bus.pwm_out = 1'b0;
`endif

  assign bus.sample_out = sample_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_impact_resonator.sv
// Directed bench for impact_resonator with hand-computed expectations.
module tb_impact_resonator;
  import resonator_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  impact_resonator_if bus ();

  impact_resonator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic strike(input logic [1:0] s, input logic [3:0] t);
    @(negedge clk);
    bus.trigger_resonator = s;
    bus.tension           = t;
    @(negedge clk);
    bus.trigger_resonator = 2'd0;
  endtask

  task automatic strobe();
    @(negedge clk);
    bus.update_resonator = 1'b1;
    @(negedge clk);
    bus.update_resonator = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.update_resonator  = 1'b0;
    bus.trigger_resonator = 2'd0;
    bus.tension           = 4'd0;
    repeat (3) @(negedge clk);
    check_val("rst_sample", bus.sample_out, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_pwm", bus.pwm_out, 0);
    check_val("rst_env", dut.u_env.env_q, 0);
    rst = 1'b0;

    // Strength 3, tension 0: attack ramp to 255
    strike(2'd3, 4'd0);
    check_val("pend_set", dut.pend_q, 1);
    strobe();
    check_val("s3_env0", dut.u_env.env_q, 32);
    check_val("s3_state", dut.u_env.state_q, ATTACK);
    check_val("s3_inc", dut.inc_q, 512);
    check_val("s3_pend_clr", dut.pend_q, 0);
    for (int i = 1; i < 7; i++) begin
      strobe();
      check_val($sformatf("s3_env%0d", i), dut.u_env.env_q, 32 * (i + 1));
      if (i == 2) check_val("s3_sample2", bus.sample_out, 1);
      if (i == 3) check_val("s3_sample3", bus.sample_out, 3);
    end
    strobe();
    check_val("s3_env_top", dut.u_env.env_q, 255);
    check_val("s3_decay", dut.u_env.state_q, DECAY);
    strobe();
    check_val("s3_env_dec", dut.u_env.env_q, 240);

    // Reset mid-tone, with a strike pending that must be lost
    strike(2'd2, 4'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_sample", bus.sample_out, 0);
    check_val("midrst_busy", bus.busy, 0);
    check_val("midrst_pwm", bus.pwm_out, 0);
    @(negedge clk);
    rst = 1'b0;
    strobe();
    strobe();
    check_val("postrst_busy", bus.busy, 0);
    check_val("postrst_sample", bus.sample_out, 0);

    // Strength 1: peak 85 then decay to idle
    strike(2'd1, 4'd0);
    strobe();
    strobe();
    strobe();
    check_val("w_env_peak", dut.u_env.env_q, 85);
    check_val("w_decay", dut.u_env.state_q, DECAY);
    strobe();
    check_val("w_env_dec", dut.u_env.env_q, 80);
    n = 0;
    while (bus.busy && n < 200) begin
      strobe();
      n++;
    end
    check_val("w_idle_in_time", (n < 200), 1);
    check_val("w_env_zero", dut.u_env.env_q, 0);
    strobe();
    strobe();
    check_val("w_sample_silent", bus.sample_out, 0);

    // Strike coincident with a strobe
    @(negedge clk);
    bus.update_resonator  = 1'b1;
    bus.trigger_resonator = 2'd2;
    bus.tension           = 4'd14;
    @(negedge clk);
    bus.update_resonator  = 1'b0;
    bus.trigger_resonator = 2'd0;
    check_val("co_state", dut.u_env.state_q, ATTACK);
    check_val("co_env", dut.u_env.env_q, 32);
    check_val("co_inc", dut.inc_q, 4096);
    check_val("co_target", dut.u_env.target_q, 170);
    check_val("co_pend", dut.pend_q, 0);

    // Two strikes between strobes: last wins
    strike(2'd1, 4'd2);
    strike(2'd3, 4'd4);
    strobe();
    check_val("two_target", dut.u_env.target_q, 255);
    check_val("two_env", dut.u_env.env_q, 32);
    check_val("two_inc", dut.inc_q, 1536);

    // Retrigger during decay
    n = 0;
    while (dut.u_env.state_q != DECAY && n < 20) begin
      strobe();
      n++;
    end
    check_val("rt_reached_decay", dut.u_env.state_q, DECAY);
    strobe();
    strike(2'd2, 4'd1);
    strobe();
    check_val("rt_phase", dut.phase_q, 0);
    check_val("rt_env", dut.u_env.env_q, 32);
    check_val("rt_state", dut.u_env.state_q, ATTACK);
    check_val("rt_inc", dut.inc_q, 768);

    // Known sample for PWM: strength 3 tension 15
    strike(2'd3, 4'd15);
    strobe();
    strobe();
    strobe();
    check_val("pw_sample2", bus.sample_out, 8);
    strobe();
    check_val("pw_sample3", bus.sample_out, 25);
    strobe();
    check_val("pw_sample4", bus.sample_out, 51);
    strobe();
    check_val("pw_sample5", bus.sample_out, 85);
    @(negedge clk);
    @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (bus.pwm_out) hi++;
      @(negedge clk);
    end
`ifdef RESONATOR_PWM_EN
    check_val("pwm_high_count", hi, 85);
`else
    check_val("pwm_high_count", hi, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
